// File: rtl/spi_cpu_bridge_if.sv
// Link between the CPU bridge and the SPI master: launch handshake plus receive report.
// master = bridge side, slave = SPI master side.
`ifndef W_CPU
`define W_CPU 32
`endif

interface spi_cpu_bridge_if #(
  parameter int W_Data = `W_CPU
) ();
  logic [W_Data-1:0] spi_data_to_transmit;
  logic              spi_data_transmit_valid;
  logic              spi_transmit_ready;
  logic [W_Data-1:0] spi_data_in;
  logic              spi_data_in_valid;

  modport master (
    output spi_data_to_transmit,
    output spi_data_transmit_valid,
    input  spi_transmit_ready,
    input  spi_data_in,
    input  spi_data_in_valid
  );

  modport slave (
    input  spi_data_to_transmit,
    input  spi_data_transmit_valid,
    output spi_transmit_ready,
    output spi_data_in,
    output spi_data_in_valid
  );
endinterface

// File: rtl/spi_cpu_bridge.sv
// CPU front end for the SPI master: TX FIFO with one-at-a-time launch, RX holding register.
// Define SPI_BRIDGE_IRQ_EN to add irq_mask input and registered irq output.
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | waiting for a queued word and master ready; launches on both
// WAIT_ACCEPT | launch pulse issued, waiting for master to drop ready
// WAIT_DONE   | master busy shifting, waiting for ready to return
`ifndef W_CPU
`define W_CPU 32
`endif

module spi_cpu_bridge #(
  parameter int W_Data     = `W_CPU,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [W_Data-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic                  clr_status,
  output logic [W_Data-1:0]     rd_data,
  output logic                  rx_valid,
  output logic                  rx_overrun,
  output logic                  tx_drop,
  output logic                  tx_full,
  output logic [DEPTH_LOG2:0]   tx_count,
  output logic                  busy,
`ifdef SPI_BRIDGE_IRQ_EN
  input  logic [2:0]            irq_mask,
  output logic                  irq,
`endif
  spi_cpu_bridge_if.master      spi
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ACCEPT = 2'd1,
    WAIT_DONE   = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [W_Data-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]    count;
  logic                   fifo_empty;
  logic                   launch;
  logic                   push;
  logic                   din_valid_q;
  logic                   rx_edge;

  assign fifo_empty = (count == '0);
  assign tx_full    = (count == FULL_CNT);
  assign tx_count   = count;
  assign busy       = (state != IDLE) || !fifo_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign push       = wr_en && (!tx_full || launch);
  assign rx_edge    = spi.spi_data_in_valid && !din_valid_q;

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && spi.spi_transmit_ready) begin
          launch    = 1'b1;
          state_nxt = WAIT_ACCEPT;
        end
      end
      WAIT_ACCEPT: if (!spi.spi_transmit_ready) state_nxt = WAIT_DONE;
      WAIT_DONE:   if (spi.spi_transmit_ready)  state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (launch) rd_ptr <= rd_ptr + 1'b1;
      case ({push, launch})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spi.spi_data_to_transmit    <= '0;
      spi.spi_data_transmit_valid <= 1'b0;
    end else begin
      if (launch) spi.spi_data_to_transmit <= mem[rd_ptr];
      spi.spi_data_transmit_valid <= launch;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_valid_q <= 1'b0;
      rd_data     <= '0;
      rx_valid    <= 1'b0;
    end else begin
      din_valid_q <= spi.spi_data_in_valid;
      if (rx_edge) begin
        rd_data  <= spi.spi_data_in;
        rx_valid <= 1'b1;
      end else if (rd_en) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // Sticky flags: a set event outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_overrun <= 1'b0;
      tx_drop    <= 1'b0;
    end else begin
      if (rx_edge && rx_valid && !rd_en) rx_overrun <= 1'b1;
      else if (clr_status)               rx_overrun <= 1'b0;
      if (wr_en && tx_full && !launch)   tx_drop <= 1'b1;
      else if (clr_status)               tx_drop <= 1'b0;
    end
  end

`ifdef SPI_BRIDGE_IRQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq <= 1'b0;
    else      irq <= (rx_valid & irq_mask[0]) |
                     ((rx_overrun | tx_drop) & irq_mask[1]) |
                     (!busy & irq_mask[2]);
  end
`endif

endmodule

// File: tb/tb_spi_cpu_bridge.sv
// Directed self-checking bench for spi_cpu_bridge; master behaviour is driven by hand.
module tb_spi_cpu_bridge;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          rd_en = 1'b0;
  logic          clr_status = 1'b0;
  logic [W-1:0]  rd_data;
  logic          rx_valid, rx_overrun, tx_drop, tx_full, busy;
  logic [2:0]    tx_count;
`ifdef SPI_BRIDGE_IRQ_EN
  logic [2:0]    irq_mask = 3'b000;
  logic          irq;
`endif

  int checks = 0;
  int errors = 0;

  spi_cpu_bridge_if #(.W_Data(W)) spi_bus ();

  spi_cpu_bridge #(.W_Data(W), .DEPTH_LOG2(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .clr_status (clr_status),
    .rd_data    (rd_data),
    .rx_valid   (rx_valid),
    .rx_overrun (rx_overrun),
    .tx_drop    (tx_drop),
    .tx_full    (tx_full),
    .tx_count   (tx_count),
    .busy       (busy),
`ifdef SPI_BRIDGE_IRQ_EN
    .irq_mask   (irq_mask),
    .irq        (irq),
`endif
    .spi        (spi_bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    spi_bus.spi_transmit_ready = 1'b1;
    spi_bus.spi_data_in        = '0;
    spi_bus.spi_data_in_valid  = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({rx_valid, rx_overrun, tx_drop, tx_full, busy, spi_bus.spi_data_transmit_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000000", {rx_valid, rx_overrun, tx_drop, tx_full, busy, spi_bus.spi_data_transmit_valid});
    end
    checks++;
    if (tx_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", tx_count); end
    checks++;
    if (rd_data !== 32'h0 || spi_bus.spi_data_to_transmit !== 32'h0) begin
      errors++; $display("FAIL reset_data got %h/%h exp 0/0", rd_data, spi_bus.spi_data_to_transmit);
    end
    #4 rst = 1'b1;
    tick();
  endtask

  task automatic test_single_launch();
    wr_en = 1'b1; wr_data = 32'hA5A5_0001;
    tick();
    wr_en = 1'b0;
    checks++;
    if (tx_count !== 3'd1 || spi_bus.spi_data_transmit_valid !== 1'b0) begin
      errors++; $display("FAIL single_queued got cnt %0d v %b exp 1 0", tx_count, spi_bus.spi_data_transmit_valid);
    end
    tick();
    checks++;
    if (spi_bus.spi_data_transmit_valid !== 1'b1 || spi_bus.spi_data_to_transmit !== 32'hA5A5_0001) begin
      errors++; $display("FAIL single_pulse got v %b d %h exp 1 a5a50001", spi_bus.spi_data_transmit_valid, spi_bus.spi_data_to_transmit);
    end
    checks++;
    if (tx_count !== 3'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL single_pop got cnt %0d busy %b exp 0 1", tx_count, busy);
    end
    tick();
    checks++;
    if (spi_bus.spi_data_transmit_valid !== 1'b0 || spi_bus.spi_data_to_transmit !== 32'hA5A5_0001) begin
      errors++; $display("FAIL single_one_cycle got v %b d %h exp 0 a5a50001", spi_bus.spi_data_transmit_valid, spi_bus.spi_data_to_transmit);
    end
    spi_bus.spi_transmit_ready = 1'b0;
    tick();
    spi_bus.spi_transmit_ready = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got busy %b exp 0", busy); end
  endtask

  task automatic test_fifo_full_drop();
    spi_bus.spi_transmit_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 32'hC0DE_0000 + i;
      tick();
    end
    checks++;
    if (tx_full !== 1'b1 || tx_count !== 3'd4 || tx_drop !== 1'b0) begin
      errors++; $display("FAIL full_level got full %b cnt %0d drop %b exp 1 4 0", tx_full, tx_count, tx_drop);
    end
    wr_data = 32'hDEAD_DEAD;
    tick();
    wr_en = 1'b0;
    checks++;
    if (tx_drop !== 1'b1 || tx_count !== 3'd4) begin
      errors++; $display("FAIL full_drop got drop %b cnt %0d exp 1 4", tx_drop, tx_count);
    end
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    checks++;
    if (tx_drop !== 1'b0) begin errors++; $display("FAIL drop_clear got %b exp 0", tx_drop); end
    for (int i = 0; i < 4; i++) begin
      spi_bus.spi_transmit_ready = 1'b1;
      tick();
      checks++;
      if (spi_bus.spi_data_transmit_valid !== 1'b1 || spi_bus.spi_data_to_transmit !== (32'hC0DE_0000 + i)
          || tx_count !== 3'(3 - i)) begin
        errors++;
        $display("FAIL drain_word%0d got v %b d %h cnt %0d exp 1 %h %0d", i, spi_bus.spi_data_transmit_valid,
                 spi_bus.spi_data_to_transmit, tx_count, 32'hC0DE_0000 + i, 3 - i);
      end
      spi_bus.spi_transmit_ready = 1'b0;
      tick();
      spi_bus.spi_transmit_ready = 1'b1;
      tick();
      checks++;
      if (spi_bus.spi_data_transmit_valid !== 1'b0) begin
        errors++; $display("FAIL drain_gap%0d got v %b exp 0", i, spi_bus.spi_data_transmit_valid);
      end
    end
    checks++;
    if (busy !== 1'b0 || tx_count !== 3'd0) begin
      errors++; $display("FAIL drain_done got busy %b cnt %0d exp 0 0", busy, tx_count);
    end
  endtask

  task automatic test_rx_level();
    spi_bus.spi_data_in = 32'h0000_00C3;
    spi_bus.spi_data_in_valid = 1'b1;
    tick();
    spi_bus.spi_data_in = 32'h0000_0077;
    tick();
    tick();
    spi_bus.spi_data_in_valid = 1'b0;
    checks++;
    if (rx_valid !== 1'b1 || rd_data !== 32'h0000_00C3 || rx_overrun !== 1'b0) begin
      errors++; $display("FAIL rx_level got v %b d %h ovr %b exp 1 000000c3 0", rx_valid, rd_data, rx_overrun);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rx_valid !== 1'b0 || rd_data !== 32'h0000_00C3) begin
      errors++; $display("FAIL rx_read got v %b d %h exp 0 000000c3", rx_valid, rd_data);
    end
  endtask

  task automatic rx_pulse(input logic [W-1:0] d, input logic rd, input logic clr);
    spi_bus.spi_data_in = d; spi_bus.spi_data_in_valid = 1'b1; rd_en = rd; clr_status = clr;
    tick();
    spi_bus.spi_data_in_valid = 1'b0; rd_en = 1'b0; clr_status = 1'b0;
    tick();
  endtask

  task automatic test_rx_overrun();
    rx_pulse(32'h0000_0011, 1'b0, 1'b0);
    rx_pulse(32'h0000_0022, 1'b0, 1'b0);
    checks++;
    if (rd_data !== 32'h0000_0022 || rx_overrun !== 1'b1 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL rx_overrun got d %h ovr %b v %b exp 00000022 1 1", rd_data, rx_overrun, rx_valid);
    end
    clr_status = 1'b1; rd_en = 1'b1;
    tick();
    clr_status = 1'b0; rd_en = 1'b0;
    checks++;
    if (rx_overrun !== 1'b0 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL rx_clear got ovr %b v %b exp 0 0", rx_overrun, rx_valid);
    end
    rx_pulse(32'h0000_0033, 1'b0, 1'b0);
    rx_pulse(32'h0000_0044, 1'b1, 1'b0);
    checks++;
    if (rd_data !== 32'h0000_0044 || rx_overrun !== 1'b0 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL rx_read_coincident got d %h ovr %b v %b exp 00000044 0 1", rd_data, rx_overrun, rx_valid);
    end
    rx_pulse(32'h0000_0055, 1'b0, 1'b1);
    checks++;
    if (rx_overrun !== 1'b1 || rd_data !== 32'h0000_0055) begin
      errors++; $display("FAIL set_beats_clear got ovr %b d %h exp 1 00000055", rx_overrun, rd_data);
    end
    clr_status = 1'b1; rd_en = 1'b1;
    tick();
    clr_status = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    spi_bus.spi_transmit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 32'h5A00_0000 + i;
      tick();
    end
    wr_en = 1'b0;
    spi_bus.spi_transmit_ready = 1'b1;
    tick();
    checks++;
    if (spi_bus.spi_data_transmit_valid !== 1'b1 || spi_bus.spi_data_to_transmit !== 32'h5A00_0000) begin
      errors++; $display("FAIL mid_launch got v %b d %h exp 1 5a000000", spi_bus.spi_data_transmit_valid, spi_bus.spi_data_to_transmit);
    end
    spi_bus.spi_transmit_ready = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (tx_count !== 3'd0 || busy !== 1'b0 || spi_bus.spi_data_to_transmit !== 32'h0
        || spi_bus.spi_data_transmit_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset got cnt %0d busy %b d %h v %b exp 0 0 0 0", tx_count, busy,
                         spi_bus.spi_data_to_transmit, spi_bus.spi_data_transmit_valid);
    end
    spi_bus.spi_transmit_ready = 1'b1;
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (spi_bus.spi_data_transmit_valid !== 1'b0 || tx_count !== 3'd0) begin
        errors++; $display("FAIL post_reset_quiet%0d got v %b cnt %0d exp 0 0", i, spi_bus.spi_data_transmit_valid, tx_count);
      end
    end
    wr_en = 1'b1; wr_data = 32'hBEEF_0001;
    tick();
    wr_en = 1'b0;
    tick();
    checks++;
    if (spi_bus.spi_data_transmit_valid !== 1'b1 || spi_bus.spi_data_to_transmit !== 32'hBEEF_0001) begin
      errors++; $display("FAIL post_reset_push got v %b d %h exp 1 beef0001", spi_bus.spi_data_transmit_valid, spi_bus.spi_data_to_transmit);
    end
    spi_bus.spi_transmit_ready = 1'b0;
    tick();
    spi_bus.spi_transmit_ready = 1'b1;
    tick();
  endtask

`ifdef SPI_BRIDGE_IRQ_EN
  task automatic test_irq();
    irq_mask = 3'b000;
    tick();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked got %b exp 0", irq); end
    wr_en = 1'b1; wr_data = 32'h0000_1234;
    tick();
    wr_en = 1'b0;
    irq_mask = 3'b100;
    tick();
    spi_bus.spi_transmit_ready = 1'b0;
    tick();
    spi_bus.spi_transmit_ready = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || irq !== 1'b0) begin
      errors++; $display("FAIL irq_lag got busy %b irq %b exp 0 0", busy, irq);
    end
    tick();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %b exp 1", irq); end
    irq_mask = 3'b000;
    tick();
    tick();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_off got %b exp 0", irq); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_launch();
    test_fifo_full_drop();
    test_rx_level();
    test_rx_overrun();
    test_reset_mid();
`ifdef SPI_BRIDGE_IRQ_EN
    test_irq();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_cpu_bridge.md
Name: spi_cpu_bridge

Overview:
- CPU-side front end for the SPI master.
- Buffers CPU write words in a small TX FIFO and launches them one at a time into the SPI master using its ready/valid handshake.
- Captures each word the master reports as received into a CPU-readable RX holding register, with status flags.
- Sits between the CPU load/store path (upstream) and the SPI master (downstream).

Parameters:
- W_Data, `W_CPU, data word width; must match the SPI master's W_Data.
- DEPTH_LOG2, 2, log2 of TX FIFO depth (default depth 4).

Ports:
- clk  input  1  system clock; all state on posedge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- wr_en  input  1  CPU push strobe into TX FIFO.
- wr_data  input  W_Data  word to push.
- rd_en  input  1  CPU pop strobe for RX register.
- clr_status  input  1  clears sticky flags.
- rd_data  output  W_Data  RX holding register.
- rx_valid  output  1  rd_data holds an unread word.
- rx_overrun  output  1  sticky: an unread RX word was overwritten.
- tx_drop  output  1  sticky: a push arrived while the FIFO was full.
- tx_full  output  1  FIFO count == 2^DEPTH_LOG2.
- tx_count  output  DEPTH_LOG2+1  FIFO occupancy.
- busy  output  1  FSM not IDLE, or FIFO non-empty.
- spi_data_to_transmit  output  W_Data  word to the master.
- spi_data_transmit_valid  output  1  one-cycle launch pulse to the master.
- spi_transmit_ready  input  1  master's MOSI ready flag.
- spi_data_in  input  W_Data  master's received word.
- spi_data_in_valid  input  1  master's receive-complete flag (may be level).

Behaviour:
- Reset (rst=0, async):
  - FIFO pointers and count cleared.
  - rd_data=0; rx_valid, rx_overrun, tx_drop = 0.
  - spi_data_to_transmit=0; spi_data_transmit_valid=0.
  - FSM=IDLE; edge-detect register=0.
- Reset mid-transfer: FIFO contents discarded; no further pulse issued.
- TX FIFO:
  - Circular buffer, registered read/write pointers wrapping mod depth.
  - Push accepted when wr_en && (!tx_full || pop this cycle).
  - Push rejected when full with no pop: word dropped, tx_drop set.
  - Push into an empty FIFO is visible to the FSM next cycle (1-cycle minimum latency, wr_en to launch pulse).
- FSM states:
  - IDLE: if FIFO non-empty && spi_transmit_ready=1, then:
    - drive spi_data_to_transmit = head word,
    - assert spi_data_transmit_valid for exactly 1 cycle,
    - pop the FIFO,
    - go to WAIT_ACCEPT.
  - WAIT_ACCEPT: hold spi_data_to_transmit stable; valid=0.
    - spi_transmit_ready=0 -> WAIT_DONE.
  - WAIT_DONE: hold data stable.
    - spi_transmit_ready=1 -> IDLE.
    - The next launch may occur on the following cycle at earliest; no back-to-back pulses.
- spi_data_transmit_valid is never asserted outside the IDLE->WAIT_ACCEPT transition.
- RX capture:
  - Rising-edge detect on spi_data_in_valid (registered previous value); level-high input captures once per edge.
  - On edge: rd_data <= spi_data_in; rx_valid <= 1.
  - If rx_valid was already 1 and rd_en=0 that cycle: set rx_overrun.
  - Edge and rd_en in the same cycle: new word loaded, rx_valid stays 1, no overrun.
  - rd_en with no edge: rx_valid <= 0; rd_data is held.
- Sticky flags:
  - clr_status clears rx_overrun and tx_drop.
  - A set event in the same cycle as clr_status wins: flag = 1.
- tx_count, tx_full and busy are registered-state derived; no combinational path from wr_en.

Optional Feature:
- Macro SPI_BRIDGE_IRQ_EN.
- When defined:
  - Adds input irq_mask [2:0]: bit0 rx, bit1 error, bit2 tx-empty.
  - Adds registered output irq = (rx_valid & mask[0]) | ((rx_overrun|tx_drop) & mask[1]) | (!busy & mask[2]).
  - irq resets to 0.
- When undefined: neither port exists; behaviour otherwise identical.

Test Plan:
- Reset release, model master ready=1, push 0xA5A5_0001 -> launch pulse 1 cycle after push with data 0xA5A5_0001; FSM WAIT_ACCEPT; tx_count back to 0.
- Push 5 words into depth-4 FIFO with master held busy (ready=0) -> tx_full=1, 5th word dropped, tx_drop=1; clr_status clears it; the 4 words emerge in order, each pulse gated by ready 0->1->...
- spi_data_in_valid held high 3 cycles with data 0x0000_00C3 -> exactly one capture; rx_valid=1, rd_data=0x0000_00C3; rd_en -> rx_valid=0.
- Two RX edges without rd_en -> rd_data = second word, rx_overrun=1; repeat with rd_en coincident with second edge -> rx_overrun stays 0, rx_valid=1.
- Assert rst=0 asynchronously mid-WAIT_DONE with 2 words queued -> outputs zero immediately, tx_count=0, no launch after release until a new push.
- With SPI_BRIDGE_IRQ_EN, mask=3'b100, drain FIFO -> irq rises 1 cycle after busy falls; mask=0 -> irq stays 0.
